// File: rtl/barrel_shifter.sv
// ---------------------------------------------------------------------------
// barrel_shifter
//
// Purpose:
//   Single-cycle logical barrel shifter with one registered output stage.
//   A DATA_WIDTH-bit word is shifted left or right by 0..DATA_WIDTH-1
//   positions. Vacated bit positions are always filled with zeros.
//
//   The datapath is a log2 network of 2:1 mux stages. Stage k shifts right
//   by 2^k when shift[k] is set. Only a right-shift network is built. A
//   left shift is produced by bit-reversing the word on the way in,
//   shifting right, and bit-reversing the result on the way out.
//
// Ports:
//   clk       in   1            rising-edge clock for all state
//   rst_n     in   1            synchronous reset, active low
//   RbarL     in   1            direction: 0 = shift right, 1 = shift left
//   shift     in   SHIFT_W      unsigned shift distance, 0..DATA_WIDTH-1
//   data_in   in   DATA_WIDTH   word to be shifted
//   data_out  out  DATA_WIDTH   registered shifted result (1-cycle latency)
// ---------------------------------------------------------------------------
module barrel_shifter #(
  parameter  int DATA_WIDTH = 8,
  localparam int SHIFT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RbarL,
  input  logic [SHIFT_W-1:0]    shift,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  // Mirror a word end-for-end so that a right shift of the mirrored word
  // is equivalent to a left shift of the original word.
  function automatic logic [DATA_WIDTH-1:0] bitReverse(
    input logic [DATA_WIDTH-1:0] value
  );
    logic [DATA_WIDTH-1:0] result;
    result = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      result[i] = value[DATA_WIDTH-1-i];
    end
    return result;
  endfunction

  logic [DATA_WIDTH-1:0] networkIn;
  logic [DATA_WIDTH-1:0] stageData [SHIFT_W+1];
  logic [DATA_WIDTH-1:0] dataOut_d;
  logic [DATA_WIDTH-1:0] dataOut_q;

  // Present the right-shift network with the word in the orientation that
  // makes a right shift do the requested job. For a left shift, the word is
  // mirrored first.
  always_comb begin
    networkIn = data_in;
    if (RbarL) begin
      networkIn = bitReverse(data_in);
    end
  end

  assign stageData[0] = networkIn;

  // Each stage either passes its input through or shifts it right by its
  // power-of-two distance. Zeros enter from the top. Because every stage is
  // a fully specified 2:1 mux, every output bit is defined for all inputs.
  for (genvar k = 0; k < SHIFT_W; k++) begin : gen_stage
    localparam int STEP = 1 << k;
    assign stageData[k+1] = shift[k] ? (stageData[k] >> STEP) : stageData[k];
  end

  // Undo the input mirroring for left shifts. The bits that were shifted
  // past the LSB of the mirrored word are exactly the ones a left shift
  // discards past the MSB.
  always_comb begin
    dataOut_d = stageData[SHIFT_W];
    if (RbarL) begin
      dataOut_d = bitReverse(stageData[SHIFT_W]);
    end
  end

  // Output register. Reset wins over any input activity on the same edge.
  // Otherwise a fresh result is captured every cycle with no enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dataOut_q <= '0;
    end else begin
      dataOut_q <= dataOut_d;
    end
  end

  assign data_out = dataOut_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// ---------------------------------------------------------------------------
// tb_barrel_shifter
//
// Scoreboard bench for barrel_shifter (DATA_WIDTH = 8).
//
// Stimulus side:
//   The stimulus drives inputs on the falling edge. After the rising edge
//   that captures those inputs, it pushes the expected data_out and a short
//   label into queues.
//
// Monitor side:
//   On every falling edge, the monitor pops one expectation, if one is
//   pending, and compares it against data_out.
// ---------------------------------------------------------------------------
module tb_barrel_shifter;

  logic       clk;
  logic       rst_n;
  logic       RbarL;
  logic [2:0] shift;
  logic [7:0] data_in;
  logic [7:0] data_out;

  logic [7:0] expQ[$];
  string      nameQ[$];
  int         checks;
  int         failures;

  barrel_shifter #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RbarL    (RbarL),
    .shift    (shift),
    .data_in  (data_in),
    .data_out (data_out)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference shift built from the language operators. This is independent
  // of the mux-network structure used in the design.
  function automatic logic [7:0] refShift(
    input logic [7:0] d,
    input logic [2:0] sh,
    input logic       left
  );
    return left ? (d << sh) : (d >> sh);
  endfunction

  // Drive one cycle of inputs, let the DUT capture them, then record what
  // data_out must show after that capturing edge.
  task automatic applyStimulus(
    input logic       rst,
    input logic       left,
    input logic [2:0] sh,
    input logic [7:0] din,
    input logic [7:0] exp,
    input string      name
  );
    @(negedge clk);
    rst_n   = rst;
    RbarL   = left;
    shift   = sh;
    data_in = din;
    @(posedge clk);
    expQ.push_back(exp);
    nameQ.push_back(name);
  endtask

  // Compare one popped expectation against the current output.
  task automatic checkOutput(input logic [7:0] exp, input string name);
    checks++;
    if (data_out !== exp) begin
      failures++;
      $display("[TB] FAIL %s: data_out=%h expected=%h", name, data_out, exp);
    end
  endtask

  // Monitor: the output is stable mid-cycle, so sample on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        checkOutput(expQ.pop_front(), nameQ.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] rightExp [8];
    logic [7:0] leftExp  [8];
    logic [7:0] d;
    logic [2:0] sh;
    logic       dir;
    int         waitCycles;

    rightExp = '{8'hB5, 8'h5A, 8'h2D, 8'h16, 8'h0B, 8'h05, 8'h02, 8'h01};
    leftExp  = '{8'hB5, 8'h6A, 8'hD4, 8'hA8, 8'h50, 8'hA0, 8'h40, 8'h80};
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    RbarL    = 1'b0;
    shift    = '0;
    data_in  = '0;

    // Reset holds the output at zero even with live inputs applied.
    applyStimulus(1'b0, 1'b1, 3'd3, 8'hFF, 8'h00, "reset_edge0");
    applyStimulus(1'b0, 1'b1, 3'd3, 8'hFF, 8'h00, "reset_edge1");
    applyStimulus(1'b1, 1'b1, 3'd3, 8'hFF, 8'hF8, "first_after_reset");

    // Directed sweeps over every distance in both directions.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 3'(i), 8'hB5, rightExp[i],
                    $sformatf("right_sweep_%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 3'(i), 8'hB5, leftExp[i],
                    $sformatf("left_sweep_%0d", i));
    end

    // Maximum distance keeps only the edge bit. An all-zero word stays zero.
    applyStimulus(1'b1, 1'b0, 3'd7, 8'h81, 8'h01, "extreme_right");
    applyStimulus(1'b1, 1'b1, 3'd7, 8'h81, 8'h80, "extreme_left");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'(i & 1), 3'(i), 8'h00, 8'h00,
                    $sformatf("zero_word_%0d", i));
    end

    // Back-to-back traffic with every input changing each cycle.
    for (int i = 0; i < 16; i++) begin
      d   = 8'($urandom);
      sh  = 3'($urandom_range(7, 0));
      dir = 1'($urandom_range(1, 0));
      applyStimulus(1'b1, dir, sh, d, refShift(d, sh, dir),
                    $sformatf("b2b_%0d", i));
    end

    // One reset edge in the middle of traffic, then traffic resumes.
    for (int i = 0; i < 6; i++) begin
      d   = 8'($urandom);
      sh  = 3'($urandom_range(7, 0));
      dir = 1'($urandom_range(1, 0));
      if (i == 3) begin
        applyStimulus(1'b0, dir, sh, d, 8'h00, "midstream_reset");
      end else begin
        applyStimulus(1'b1, dir, sh, d, refShift(d, sh, dir),
                      $sformatf("midstream_%0d", i));
      end
    end

    // Let the monitor drain the remaining expectations, with a cycle bound.
    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    @(posedge clk);
    if (expQ.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain_timeout: pending=%0d expected=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
